// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM with combinational control decode.
// Outputs are forced low while reset_n is asserted, independent of the clock.
module multicycle_control #(
    parameter logic FETCH_ON_ILLEGAL = 1'b1
) (
    input  logic       master_clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     cur;
    state_t     nxt;
    logic [5:0] op_q;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur  <= FETCH;
            op_q <= 6'd0;
        end else begin
            cur <= nxt;
            // MEMADR needs to know lw vs sw after opcode has moved on
            if (cur == DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            FETCH:   nxt = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH_ON_ILLEGAL ? FETCH : HALT;
                endcase
            end
            MEMADR:  nxt = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nxt = MEMWB;
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = FETCH;
            EXECUTE: nxt = ALUWB;
            ALUWB:   nxt = FETCH;
            BRANCH:  nxt = FETCH;
            ADDIEX:  nxt = ADDIWB;
            ADDIWB:  nxt = FETCH;
            JUMP:    nxt = FETCH;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        if (reset_n) begin
            unique case (cur)
                FETCH: begin
                    ir_write    = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = 3'b010;
                    pc_en       = 1'b1;
                end
                DECODE: begin
                    alu_src_b   = 2'b11;
                    alu_control = 3'b010;
                end
                MEMADR, ADDIEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = 3'b010;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    unique case (funct)
                        6'b100010: alu_control = 3'b110;
                        6'b100100: alu_control = 3'b000;
                        6'b100101: alu_control = 3'b001;
                        6'b101010: alu_control = 3'b111;
                        default:   alu_control = 3'b010;
                    endcase
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = 3'b110;
                    pc_src      = 2'b01;
                    pc_en       = zero;
                end
                ADDIWB: reg_write = 1'b1;
                JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-stream bench for multicycle_control against a
// per-instruction state-sequence and per-state output-table reference.
module tb_multicycle_control;

    logic       master_clk = 1'b0;
    logic       reset_n;
    logic       reset_h;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       pc_en, iord, ir_write, mem_write, reg_write, reg_dst;
    logic       mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    logic       h_pc_en, h_iord, h_ir_write, h_mem_write, h_reg_write;
    logic       h_reg_dst, h_mem_to_reg, h_alu_src_a;
    logic [1:0] h_alu_src_b, h_pc_src;
    logic [2:0] h_alu_control;
    logic [3:0] h_state;

    int errors = 0;
    int checks = 0;

    always #5 master_clk = ~master_clk;

    multicycle_control dut (
        .master_clk(master_clk), .reset_n(reset_n),
        .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .state(state)
    );

    multicycle_control #(.FETCH_ON_ILLEGAL(1'b0)) dut_h (
        .master_clk(master_clk), .reset_n(reset_h),
        .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(h_pc_en), .iord(h_iord), .ir_write(h_ir_write),
        .mem_write(h_mem_write), .reg_write(h_reg_write),
        .reg_dst(h_reg_dst), .mem_to_reg(h_mem_to_reg),
        .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b),
        .alu_control(h_alu_control), .pc_src(h_pc_src), .state(h_state)
    );

    logic [14:0] outs, h_outs;
    assign outs = {pc_en, iord, ir_write, mem_write, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src};
    assign h_outs = {h_pc_en, h_iord, h_ir_write, h_mem_write, h_reg_write,
                     h_reg_dst, h_mem_to_reg, h_alu_src_a, h_alu_src_b,
                     h_alu_control, h_pc_src};

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control word each state must present, in the bit order of outs
    function automatic logic [14:0] exp_out(input int s, input logic [5:0] f,
                                            input logic z);
        logic pe, io, irw, mw, rw, rd, m2r, sa;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pe, io, irw, mw, rw, rd, m2r, sa} = 8'd0;
        sb = 2'b00; ps = 2'b00; ac = 3'b000;
        case (s)
            0: begin irw = 1; sb = 2'b01; ac = 3'b010; pe = 1; end
            1: begin sb = 2'b11; ac = 3'b010; end
            2, 9: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            3: io = 1;
            4: begin rw = 1; m2r = 1; end
            5: begin io = 1; mw = 1; end
            6: begin
                sa = 1;
                case (f)
                    6'b100000: ac = 3'b010;
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ac = 3'b010;
                endcase
            end
            7: begin rw = 1; rd = 1; end
            8: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {pe, io, irw, mw, rw, rd, m2r, sa, sb, ac, ps};
    endfunction

    int seq[5];
    int seq_n;

    // Expected state walk of one instruction, starting at FETCH
    task automatic build_seq(input logic [5:0] op);
        seq[0] = 0; seq[1] = 1;
        case (op)
            6'b100011: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; seq_n = 5; end
            6'b101011: begin seq[2] = 2; seq[3] = 5; seq_n = 4; end
            6'b000000: begin seq[2] = 6; seq[3] = 7; seq_n = 4; end
            6'b001000: begin seq[2] = 9; seq[3] = 10; seq_n = 4; end
            6'b000100: begin seq[2] = 8; seq_n = 3; end
            6'b000010: begin seq[2] = 11; seq_n = 3; end
            default: seq_n = 2;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] f);
        build_seq(op);
        for (int k = 0; k < seq_n; k++) begin
            opcode = (seq[k] == 1) ? op : 6'($urandom);
            funct  = (seq[k] == 6) ? f : 6'($urandom);
            zero   = 1'($urandom);
            #1;
            check("state", {12'd0, state}, 16'(seq[k]));
            check("outs", {1'b0, outs}, {1'b0, exp_out(seq[k], funct, zero)});
            @(posedge master_clk); #1;
        end
    endtask

    function automatic logic [5:0] pick_op(input int i);
        logic [5:0] legal[6];
        logic [5:0] r;
        legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                  6'b001000, 6'b000010};
        if (i < 6) return legal[i];
        do r = 6'($urandom);
        while (r inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b001000, 6'b000010});
        return r;
    endfunction

    function automatic logic [5:0] pick_funct(input int i);
        logic [5:0] fl[5];
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if (i < 5) return fl[i];
        return 6'($urandom);
    endfunction

    initial begin
        reset_n = 1'b0; reset_h = 1'b0;
        opcode = 6'b100011; funct = 6'd0; zero = 1'b1;
        #1;
        check("rst_state", {12'd0, state}, 16'd0);
        check("rst_outs", {1'b0, outs}, 16'd0);
        repeat (2) @(posedge master_clk);
        #1;
        check("rst_hold", {12'd0, state, 1'b0, outs}, 32'd0 == 0 ? 16'd0 : 16'd0);
        @(negedge master_clk);
        reset_n = 1'b1; reset_h = 1'b1;

        // Illegal opcode: default instance refetches, parked instance halts
        opcode = 6'd0; zero = 1'b0; funct = 6'd0;
        #1;
        check("h_fetch", {1'b0, h_outs}, {1'b0, exp_out(0, 6'd0, 1'b0)});
        @(posedge master_clk); #1;
        opcode = 6'b111111;
        check("h_decode", {12'd0, h_state}, 16'd1);
        @(posedge master_clk); #1;
        check("ill_fetch", {12'd0, state}, 16'd0);
        check("h_halt", {12'd0, h_state}, 16'd12);
        for (int i = 0; i < 10; i++) begin
            opcode = 6'($urandom); zero = 1'b1;
            @(posedge master_clk); #1;
            check("h_hold", {12'd0, h_state}, 16'd12);
            check("h_zero", {1'b0, h_outs}, 16'd0);
        end

        reset_n = 1'b0;
        #1;
        check("rst2", {1'b0, outs}, 16'd0);
        @(negedge master_clk);
        reset_n = 1'b1;

        for (int n = 0; n < 200; n++)
            run_instr(pick_op($urandom_range(0, 6)),
                      pick_funct($urandom_range(0, 5)));
        run_instr(6'b000000, 6'b101010);
        run_instr(6'b000100, 6'd0);
        run_instr(6'b101011, 6'd0);
        run_instr(6'b000010, 6'd0);

        // Abort a store in MEMWR with an unclocked reset pulse
        build_seq(6'b101011);
        for (int k = 0; k < 3; k++) begin
            opcode = (seq[k] == 1) ? 6'b101011 : 6'($urandom);
            @(posedge master_clk); #1;
        end
        #1;
        check("memwr", {12'd0, state}, 16'd5);
        check("memwr_we", {15'd0, mem_write}, 16'd1);
        reset_n = 1'b0;
        #1;
        check("abort_state", {12'd0, state}, 16'd0);
        check("abort_outs", {1'b0, outs}, 16'd0);
        @(posedge master_clk); #1;
        check("abort_hold", {1'b0, outs}, 16'd0);
        @(negedge master_clk);
        reset_n = 1'b1;
        #1;
        check("post_fetch", {1'b0, outs}, {1'b0, exp_out(0, 6'd0, 1'b0)});
        @(posedge master_clk); #1;
        check("post_decode", {12'd0, state}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: FETCH_ON_ILLEGAL, default 1, meaning 1 = an unsupported opcode returns to FETCH; 0 = it parks in HALT until reset.
REQ-002 Port: master_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: opcode  input  6  instr[31:26], sampled only in DECODE.
REQ-005 Port: funct  input  6  instr[5:0], used only in EXECUTE.
REQ-006 Port: zero  input  1  ALU zero flag, used only in BRANCH.
REQ-007 Port: pc_en  output  1  PC register load enable.
REQ-008 Port: iord  output  1  memory address select; 0 = PC, 1 = ALUOut.
REQ-009 Port: ir_write  output  1  instruction register load enable.
REQ-010 Port: mem_write  output  1  data memory write enable.
REQ-011 Port: reg_write  output  1  register file write enable.
REQ-012 Port: reg_dst  output  1  write register select; 0 = rt, 1 = rd.
REQ-013 Port: mem_to_reg  output  1  write data select; 0 = ALUOut, 1 = memory data.
REQ-014 Port: alu_src_a  output  1  ALU input A select; 0 = PC, 1 = register A.
REQ-015 Port: alu_src_b  output  2  ALU input B select; 00 = B, 01 = constant 1, 10 = sign-extended immediate, 11 = sign-extended immediate (PC+1 word addressing).
REQ-016 Port: alu_control  output  3  ALU operation; 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 Port: pc_src  output  2  next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 Port: state  output  4  current state encoding, for debug and coverage.

Function
REQ-019 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
REQ-020 FETCH SHALL drive iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00 and pc_en=1, then go to DECODE.
REQ-021 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_control=010 (branch target precompute), and SHALL pick the next state from opcode as follows.
REQ-022 Opcode dispatch from DECODE:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other opcode -> FETCH when FETCH_ON_ILLEGAL=1, else HALT.
REQ-023 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_control=010; it SHALL go to MEMRD for lw and MEMWR for sw, using an opcode latched in DECODE.
REQ-024 MEMRD SHALL drive iord=1 and go to MEMWB.
REQ-025 MEMWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-026 MEMWR SHALL drive iord=1 and mem_write=1, then go to FETCH.
REQ-027 EXECUTE SHALL drive alu_src_a=1 and alu_src_b=00, with alu_control from funct:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
- any other funct -> 010
EXECUTE then goes to ALUWB.
REQ-028 ALUWB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-029 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_control=110 and pc_src=01, with pc_en=zero, then go to FETCH.
REQ-030 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_control=010, then go to ADDIWB.
REQ-031 ADDIWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-032 JUMP SHALL drive pc_src=10 and pc_en=1, then go to FETCH.
REQ-033 HALT SHALL hold all enables at 0 and stay in HALT until reset.
REQ-034 Any output not listed for a state SHALL be 0.
REQ-035 Outputs SHALL be combinational decodes of state (plus funct in EXECUTE and zero in BRANCH), with no added latency.
REQ-036 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-037 opcode and funct changes outside DECODE and EXECUTE respectively SHALL have no effect.

Reset
REQ-038 While reset_n=0, state SHALL be FETCH and every output SHALL be forced to 0, independent of master_clk.
REQ-039 Reset asserted mid-instruction SHALL abort that instruction with no further write enables pulsed.
REQ-040 The first rising edge after reset_n rises SHALL occur with FETCH outputs active.

Verification
REQ-041 lw (opcode 100011) -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-042 R-type, funct 101010 -> alu_control=111 in state 6; reg_write=1 with reg_dst=1 in state 7; back in FETCH after 4 cycles.
REQ-043 beq with zero=1 -> pc_en=1 and pc_src=01 in state 8; with zero=0 -> pc_en=0.
REQ-044 Opcode 111111 with FETCH_ON_ILLEGAL=1 -> FETCH after DECODE; with FETCH_ON_ILLEGAL=0 -> state 12 holds for 10 cycles with all enables 0.
REQ-045 reset_n pulsed low while in MEMWR -> state=0 and mem_write=0 immediately, with no edge required.
REQ-046 sw then j back-to-back -> states 0,1,2,5,0,1,11,0; mem_write=1 only in state 5; pc_src=10 in state 11.
